// File: rtl/beta_clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// CTRL field positions, reset constants and the offset decoder.
package beta_clint_pkg;

  localparam logic [4:0] CLINT_MSIP        = 5'h00;
  localparam logic [4:0] CLINT_MTIMECMP_LO = 5'h04;
  localparam logic [4:0] CLINT_MTIMECMP_HI = 5'h08;
  localparam logic [4:0] CLINT_MTIME_LO    = 5'h0C;
  localparam logic [4:0] CLINT_MTIME_HI    = 5'h10;
  localparam logic [4:0] CLINT_CTRL        = 5'h14;

  localparam int unsigned CTRL_EN_BIT       = 0;
  localparam int unsigned CTRL_PRESCALE_LSB = 8;
  localparam int unsigned CTRL_PRESCALE_MSB = 23;

  localparam logic [63:0] MTIMECMP_RST = '1;

  // Misaligned or beyond-CTRL offsets are bus errors.
  function automatic logic clint_addr_err(input logic [4:0] off);
    return (off[1:0] != 2'b00) || (off > CLINT_CTRL);
  endfunction

endpackage

// File: rtl/beta_clint_prescaler.sv
// Prescaler for mtime: raises a one-cycle tick every prescale+1 enabled cycles.
module beta_clint_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] prescale,
  input  logic        clr,
  output logic        tick
);

  logic [15:0] pcnt;

  // A CTRL write restarts the count, so it also swallows a coincident tick.
  assign tick = en && !clr && (pcnt == prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      if (pcnt == prescale) pcnt <= '0;
      else                  pcnt <= pcnt + 16'd1;
    end
  end

endmodule

// File: rtl/beta_clint.sv
// Machine-level core-local interruptor: mtime/mtimecmp/msip on the data bus,
// driving level timer and software interrupts into the trap control unit.
module beta_clint
  import beta_clint_pkg::*;
#(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned ResetPrescale = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 err_o,
  output logic                 tim_intr_o,
  output logic                 sw_intr_o,
  output logic [63:0]          mtime_o
);

  localparam logic [15:0] RST_PRESCALE = 16'(ResetPrescale);

  logic [4:0]  off;
  logic        bad;
  logic        wr;
  logic        rd;
  logic        unused_addr_bits;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic        ctrl_en;
  logic [15:0] ctrl_prescale;
  logic        tick;
  logic        ctrl_wr;
  logic [31:0] rmux;

  assign off   = addr_i[4:0];
  assign bad   = clint_addr_err(off);
  assign wr    = req_i && we_i && !bad;
  assign rd    = req_i && !we_i && !bad;
  assign gnt_o = req_i;

  assign unused_addr_bits = ^addr_i[AddrWidth-1:5];

  assign ctrl_wr = wr && (off == CLINT_CTRL);
  assign mtime_o = mtime;

  beta_clint_prescaler u_prescaler (
    .clk      (clk_i),
    .rst      (rst_i),
    .en       (ctrl_en),
    .prescale (ctrl_prescale),
    .clr      (ctrl_wr),
    .tick     (tick)
  );

  always_comb begin
    rmux = '0;
    unique case (off)
      CLINT_MSIP:        rmux[0] = msip;
      CLINT_MTIMECMP_LO: rmux = mtimecmp[31:0];
      CLINT_MTIMECMP_HI: rmux = mtimecmp[63:32];
      CLINT_MTIME_LO:    rmux = mtime[31:0];
      CLINT_MTIME_HI:    rmux = mtime[63:32];
      CLINT_CTRL: begin
        rmux[CTRL_EN_BIT] = ctrl_en;
        rmux[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB] = ctrl_prescale;
      end
      default:           rmux = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= req_i;
      err_o    <= req_i && bad;
      rdata_o  <= rd ? rmux : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      msip          <= 1'b0;
      mtimecmp      <= MTIMECMP_RST;
      ctrl_en       <= 1'b1;
      ctrl_prescale <= RST_PRESCALE;
    end else if (wr) begin
      unique case (off)
        CLINT_MSIP:        msip <= wdata_i[0];
        CLINT_MTIMECMP_LO: mtimecmp[31:0]  <= wdata_i;
        CLINT_MTIMECMP_HI: mtimecmp[63:32] <= wdata_i;
        CLINT_CTRL: begin
          ctrl_en       <= wdata_i[CTRL_EN_BIT];
          ctrl_prescale <= wdata_i[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
        end
        default: ;
      endcase
    end
  end

  // A bus write to either half of mtime overrides the tick for that cycle;
  // the untouched half keeps its value and no carry is applied.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime <= '0;
    end else if (wr && (off == CLINT_MTIME_LO)) begin
      mtime[31:0] <= wdata_i;
    end else if (wr && (off == CLINT_MTIME_HI)) begin
      mtime[63:32] <= wdata_i;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tim_intr_o <= 1'b0;
      sw_intr_o  <= 1'b0;
    end else begin
      tim_intr_o <= (mtime >= mtimecmp);
      sw_intr_o  <= msip;
    end
  end

endmodule

// File: tb/tb_beta_clint.sv
// Self-checking bench for beta_clint: directed scenarios plus random bus
// traffic, all compared against a cycle-level behavioural model.
module tb_beta_clint;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        tim_intr;
  logic        sw_intr;
  logic [63:0] mtime;

  int unsigned total = 0;
  int unsigned bad = 0;

  beta_clint #(
    .DataWidth    (32),
    .AddrWidth    (32),
    .ResetPrescale(0)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .we_i      (we),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .gnt_o     (gnt),
    .rvalid_o  (rvalid),
    .rdata_o   (rdata),
    .err_o     (err),
    .tim_intr_o(tim_intr),
    .sw_intr_o (sw_intr),
    .mtime_o   (mtime)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [63:0] m_time, m_cmp;
  logic        m_msip, m_en;
  int unsigned m_pre, m_since;
  logic        e_rvalid, e_err, e_tim, e_sw;
  logic [31:0] e_rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_time = 64'd0; m_cmp = '1; m_msip = 1'b0; m_en = 1'b1;
    m_pre = 0; m_since = 0;
    e_rvalid = 1'b0; e_err = 1'b0; e_rdata = '0; e_tim = 1'b0; e_sw = 1'b0;
  endtask

  // one clock edge of the specified behaviour, using the inputs held this cycle
  task automatic model_edge(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d);
    logic [4:0] o;
    logic       er, do_wr, ctrl_w, tk;
    logic [31:0] rv;
    o  = a[4:0];
    er = (a[1:0] != 2'b00) || (o > 5'h14);
    rv = 32'd0;
    case (o)
      5'h00: rv = {31'd0, m_msip};
      5'h04: rv = m_cmp[31:0];
      5'h08: rv = m_cmp[63:32];
      5'h0C: rv = m_time[31:0];
      5'h10: rv = m_time[63:32];
      5'h14: rv = {8'd0, 16'(m_pre), 7'd0, m_en};
      default: rv = 32'd0;
    endcase
    e_rvalid = r;
    e_err    = r && er;
    e_rdata  = (r && !w && !er) ? rv : 32'd0;
    e_tim    = (m_time >= m_cmp);
    e_sw     = m_msip;
    do_wr  = r && w && !er;
    ctrl_w = do_wr && (o == 5'h14);
    tk     = m_en && !ctrl_w && (m_since == m_pre);
    if (ctrl_w) m_since = 0;
    else if (m_en) m_since = (m_since == m_pre) ? 0 : m_since + 1;
    if (do_wr && o == 5'h0C)      m_time = {m_time[63:32], d};
    else if (do_wr && o == 5'h10) m_time = {d, m_time[31:0]};
    else if (tk)                  m_time = m_time + 64'd1;
    if (do_wr) begin
      case (o)
        5'h00: m_msip = d[0];
        5'h04: m_cmp = {m_cmp[63:32], d};
        5'h08: m_cmp = {d, m_cmp[31:0]};
        5'h14: begin m_en = d[0]; m_pre = int'(d[23:8]); m_since = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d);
    req = r; we = w; addr = a; wdata = d;
    #1 chk("gnt", 64'(gnt), 64'(r));
    @(posedge clk);
    model_edge(r, w, a, d);
    #1;
    chk("rvalid", 64'(rvalid), 64'(e_rvalid));
    if (e_rvalid) begin
      chk("err", 64'(err), 64'(e_err));
      chk("rdata", 64'(rdata), 64'(e_rdata));
    end
    chk("tim_intr", 64'(tim_intr), 64'(e_tim));
    chk("sw_intr", 64'(sw_intr), 64'(e_sw));
    chk("mtime", mtime, m_time);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b0, a, 32'd0);
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_tim", 64'(tim_intr), 64'd0);
    chk("rst_sw", 64'(sw_intr), 64'd0);
    chk("rst_mtime", mtime, 64'd0);
    #10 rst = 1'b0;

    // free-run with PRESCALE=0, then read back
    idle(10);
    rd(32'h0C);
    chk("mtime_lo_after_10", 64'(rdata), 64'd10);
    rd(32'h14);
    rd(32'h04);
    rd(32'h08);

    // timer compare
    wr(32'h08, 32'd0);
    wr(32'h04, 32'd20);
    idle(8);
    wr(32'h08, 32'd1);
    idle(3);
    chk("tim_dropped", 64'(tim_intr), 64'd0);

    // software interrupt
    wr(32'h00, 32'hFFFF_FFFF);
    idle(1);
    chk("sw_set", 64'(sw_intr), 64'd1);
    rd(32'h00);
    chk("msip_read", 64'(rdata), 64'd1);
    wr(32'h00, 32'd0);
    idle(2);

    // carry into HI with PRESCALE=3
    wr(32'h14, {8'd0, 16'd3, 7'd0, 1'b1});
    wr(32'h0C, 32'hFFFF_FFFF);
    wr(32'h10, 32'd0);
    idle(4);
    chk("carry", mtime, 64'h1_0000_0000);
    idle(1);
    wr(32'h0C, 32'h1234_5678);
    idle(6);
    for (int unsigned i = 0; i < 4; i++) wr(32'h0C, 32'hABCD_0000 + i);

    // bus errors and pipelined reads
    rd(32'h18);
    rd(32'h02);
    wr(32'h1C, 32'hDEAD_BEEF);
    wr(32'h01, 32'hDEAD_BEEF);
    rd(32'h0C); rd(32'h10); rd(32'h14);

    // EN=0 freezes mtime
    wr(32'h14, {8'd0, 16'd0, 7'd0, 1'b0});
    idle(50);
    rd(32'h0C);
    wr(32'h14, {8'd0, 16'd1, 7'd0, 1'b1});
    idle(5);

    // random traffic
    for (int unsigned n = 0; n < 600; n++) begin
      logic [31:0] a, d;
      logic [4:0]  o;
      int unsigned sel;
      if ($urandom_range(0, 1) == 0) begin
        idle(1);
        continue;
      end
      sel = $urandom_range(0, 9);
      case (sel)
        0: o = 5'h00; 1: o = 5'h04; 2: o = 5'h08; 3: o = 5'h0C; 4: o = 5'h10;
        5: o = 5'h14; 6: o = 5'h18; 7: o = 5'h1C;
        default: o = 5'($urandom_range(0, 31));
      endcase
      a = {27'($urandom), o};
      d = $urandom;
      if (o == 5'h08 || o == 5'h10) d = 32'($urandom_range(0, 2));
      if (o == 5'h14) d = {8'($urandom), 16'($urandom_range(0, 5)), 7'($urandom),
                           1'($urandom_range(0, 3) != 0)};
      step(1'b1, 1'($urandom_range(0, 1)), a, d);
    end

    // asynchronous reset mid-count with the timer interrupt high
    wr(32'h14, {8'd0, 16'd0, 7'd0, 1'b1});
    wr(32'h08, 32'd0);
    wr(32'h04, 32'd0);
    idle(2);
    chk("tim_high_before_rst", 64'(tim_intr), 64'd1);
    rd(32'h0C);
    #2 rst = 1'b1;
    #1;
    chk("arst_mtime", mtime, 64'd0);
    chk("arst_tim", 64'(tim_intr), 64'd0);
    chk("arst_rvalid", 64'(rvalid), 64'd0);
    model_reset();
    #1 rst = 1'b0;
    rd(32'h04);
    rd(32'h08);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
